// File: rtl/tilt_motion_ctl_pkg.sv
// Shared types and helpers for the tilt-driven ball motion controller.
// Holds the axis state encoding, tilt bit positions and the step period function.
package tilt_motion_ctl_pkg;

    typedef enum logic [1:0] {
        AXIS_IDLE    = 2'd0,
        AXIS_QUALIFY = 2'd1,
        AXIS_MOVE    = 2'd2
    } axis_state_t;

    localparam int TILT_LEFT     = 0;
    localparam int TILT_RIGHT    = 1;
    localparam int TILT_FORWARD  = 2;
    localparam int TILT_BACKWARD = 3;

    // Ticks between steps at a given speed level; callers guarantee no underflow.
    function automatic logic [31:0] step_period(
        input logic [31:0] base_period,
        input logic [31:0] period_step,
        input logic [31:0] speed
    );
        step_period = base_period - (speed * period_step);
    endfunction

endpackage

// File: rtl/tilt_motion_ctl_axis.sv
// One motion axis: debounces a pos/neg direction request, then emits
// accelerating step pulses while the direction is held.
module tilt_axis_ctl
    import tilt_motion_ctl_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 4,
    parameter int RAMP_TICKS     = 100,
    parameter int MAX_SPEED      = 7,
    parameter int BASE_PERIOD    = 64,
    parameter int PERIOD_STEP    = 8,
    localparam int SW            = $clog2(MAX_SPEED + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic [1:0]    dir_req,
    output logic          inc,
    output logic          dec,
    output logic [SW-1:0] speed
);

    localparam int QW = $clog2(DEBOUNCE_TICKS + 1);
    localparam int RW = $clog2(RAMP_TICKS + 1);
    localparam int PW = $clog2(BASE_PERIOD + 1);

    axis_state_t   state_r;
    logic          pos_r;
    logic [QW-1:0] qual_r;
    logic [PW-1:0] phase_r;
    logic [RW-1:0] ramp_r;
    logic [SW-1:0] speed_r;

    logic        dir_valid_s;
    logic        req_pos_s;
    logic        same_dir_s;
    logic        qual_done_s;
    logic        phase_done_s;
    logic        ramp_done_s;
    logic        speed_max_s;
    logic [31:0] period_s;

    assign dir_valid_s  = dir_req[1] ^ dir_req[0];
    assign req_pos_s    = dir_req[1];
    assign same_dir_s   = (req_pos_s == pos_r);
    assign qual_done_s  = (32'(qual_r) + 32'd1) >= 32'(DEBOUNCE_TICKS);
    assign period_s     = step_period(32'(BASE_PERIOD), 32'(PERIOD_STEP), 32'(speed_r));
    // >= rather than == so a speed-up that shortens the period never strands the phase
    assign phase_done_s = (32'(phase_r) + 32'd1) >= period_s;
    assign ramp_done_s  = (32'(ramp_r) + 32'd1) >= 32'(RAMP_TICKS);
    assign speed_max_s  = 32'(speed_r) >= 32'(MAX_SPEED);
    assign speed        = speed_r;

    // Axis FSM with debounce, phase, ramp and registered step pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= AXIS_IDLE;
            pos_r   <= 1'b0;
            qual_r  <= '0;
            phase_r <= '0;
            ramp_r  <= '0;
            speed_r <= '0;
            inc     <= 1'b0;
            dec     <= 1'b0;
        end else if (!tick) begin
            inc <= 1'b0;
            dec <= 1'b0;
        end else begin
            inc <= 1'b0;
            dec <= 1'b0;
            case (state_r)
                AXIS_IDLE: begin
                    if (dir_valid_s) begin
                        pos_r <= req_pos_s;
                        if (DEBOUNCE_TICKS <= 1) begin
                            state_r <= AXIS_MOVE;
                            qual_r  <= '0;
                            phase_r <= '0;
                            ramp_r  <= '0;
                            speed_r <= '0;
                            inc     <= req_pos_s;
                            dec     <= ~req_pos_s;
                        end else begin
                            state_r <= AXIS_QUALIFY;
                            qual_r  <= QW'(1);
                        end
                    end else begin
                        qual_r <= '0;
                    end
                end
                AXIS_QUALIFY: begin
                    if (!dir_valid_s) begin
                        state_r <= AXIS_IDLE;
                        qual_r  <= '0;
                    end else if (!same_dir_s) begin
                        pos_r  <= req_pos_s;
                        qual_r <= QW'(1);
                    end else if (qual_done_s) begin
                        state_r <= AXIS_MOVE;
                        qual_r  <= '0;
                        phase_r <= '0;
                        ramp_r  <= '0;
                        speed_r <= '0;
                        inc     <= pos_r;
                        dec     <= ~pos_r;
                    end else begin
                        qual_r <= qual_r + QW'(1);
                    end
                end
                AXIS_MOVE: begin
                    if (!dir_valid_s) begin
                        state_r <= AXIS_IDLE;
                        phase_r <= '0;
                        ramp_r  <= '0;
                        speed_r <= '0;
                    end else if (!same_dir_s) begin
                        state_r <= AXIS_QUALIFY;
                        pos_r   <= req_pos_s;
                        qual_r  <= QW'(1);
                        phase_r <= '0;
                        ramp_r  <= '0;
                        speed_r <= '0;
                    end else begin
                        if (phase_done_s) begin
                            phase_r <= '0;
                            inc     <= pos_r;
                            dec     <= ~pos_r;
                        end else begin
                            phase_r <= phase_r + PW'(1);
                        end
                        if (ramp_done_s) begin
                            ramp_r <= '0;
                            if (!speed_max_s) begin
                                speed_r <= speed_r + SW'(1);
                            end else begin
                                speed_r <= speed_r;
                            end
                        end else begin
                            ramp_r <= ramp_r + RW'(1);
                        end
                    end
                end
                default: begin
                    state_r <= AXIS_IDLE;
                    qual_r  <= '0;
                    phase_r <= '0;
                    ramp_r  <= '0;
                    speed_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/tilt_motion_ctl.sv
// Tilt-to-ball-step controller: registers the tilt vector, generates the
// evaluation tick and runs one motion axis per direction pair.
module tilt_motion_ctl
    import tilt_motion_ctl_pkg::*;
#(
    parameter int SYSCLK_FREQUENCY_HZ = 100000000,
    parameter int TICK_HZ             = 1000,
    parameter int DEBOUNCE_TICKS      = 4,
    parameter int RAMP_TICKS          = 100,
    parameter int MAX_SPEED           = 7,
    parameter int BASE_PERIOD         = 64,
    parameter int PERIOD_STEP         = 8,
    localparam int SW                 = $clog2(MAX_SPEED + 1)
) (
    input  logic          SYSCLK,
    input  logic          reset2,
    input  logic [3:0]    tilt,
    output logic          x_inc,
    output logic          x_dec,
    output logic          y_inc,
    output logic          y_dec,
    output logic [SW-1:0] x_speed,
    output logic [SW-1:0] y_speed
);

    localparam int DIV = SYSCLK_FREQUENCY_HZ / TICK_HZ;
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DW-1:0] div_cnt_r;
    logic [3:0]    tilt_r;
    logic          tick_s;

    assign tick_s = (div_cnt_r == DW'(DIV - 1));

    // Free-running prescaler producing one tick every DIV cycles.
    always_ff @(posedge SYSCLK) begin
        if (reset2) begin
            div_cnt_r <= '0;
        end else if (tick_s) begin
            div_cnt_r <= '0;
        end else begin
            div_cnt_r <= div_cnt_r + DW'(1);
        end
    end

    // Single input register; every decision uses this copy of tilt.
    always_ff @(posedge SYSCLK) begin
        if (reset2) begin
            tilt_r <= 4'b0000;
        end else begin
            tilt_r <= tilt;
        end
    end

    tilt_axis_ctl #(
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
        .RAMP_TICKS     (RAMP_TICKS),
        .MAX_SPEED      (MAX_SPEED),
        .BASE_PERIOD    (BASE_PERIOD),
        .PERIOD_STEP    (PERIOD_STEP)
    ) u_x_axis (
        .clk     (SYSCLK),
        .reset   (reset2),
        .tick    (tick_s),
        .dir_req ({tilt_r[TILT_RIGHT], tilt_r[TILT_LEFT]}),
        .inc     (x_inc),
        .dec     (x_dec),
        .speed   (x_speed)
    );

    tilt_axis_ctl #(
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
        .RAMP_TICKS     (RAMP_TICKS),
        .MAX_SPEED      (MAX_SPEED),
        .BASE_PERIOD    (BASE_PERIOD),
        .PERIOD_STEP    (PERIOD_STEP)
    ) u_y_axis (
        .clk     (SYSCLK),
        .reset   (reset2),
        .tick    (tick_s),
        .dir_req ({tilt_r[TILT_BACKWARD], tilt_r[TILT_FORWARD]}),
        .inc     (y_inc),
        .dec     (y_dec),
        .speed   (y_speed)
    );

endmodule

// File: tb/tb_tilt_motion_ctl.sv
// Directed bench for tilt_motion_ctl with DIV=10, debounce 4, ramp 3, speeds 0..2.
// Cycle numbers count clock edges after reset release; ticks land on multiples of 10.
module tb_tilt_motion_ctl;

    logic       SYSCLK = 1'b0;
    logic       reset2;
    logic [3:0] tilt;
    logic       x_inc, x_dec, y_inc, y_dec;
    logic [1:0] x_speed, y_speed;

    int chk_cnt   = 0;
    int pass_cnt  = 0;
    int cyc       = 0;
    int both_seen = 0;
    int x_inc_log[$];
    int x_dec_log[$];
    int y_inc_log[$];
    int y_dec_log[$];

    tilt_motion_ctl #(
        .SYSCLK_FREQUENCY_HZ (1000),
        .TICK_HZ             (100),
        .DEBOUNCE_TICKS      (4),
        .RAMP_TICKS          (3),
        .MAX_SPEED           (2),
        .BASE_PERIOD         (8),
        .PERIOD_STEP         (2)
    ) dut (
        .SYSCLK  (SYSCLK),
        .reset2  (reset2),
        .tilt    (tilt),
        .x_inc   (x_inc),
        .x_dec   (x_dec),
        .y_inc   (y_inc),
        .y_dec   (y_dec),
        .x_speed (x_speed),
        .y_speed (y_speed)
    );

    always #5 SYSCLK = ~SYSCLK;

    // Pulse logger on the falling edge: cyc is the index of the rising edge just seen.
    initial begin
        forever begin
            @(negedge SYSCLK);
            if (reset2) cyc = 0;
            else cyc = cyc + 1;
            if (x_inc === 1'b1) x_inc_log.push_back(cyc);
            if (x_dec === 1'b1) x_dec_log.push_back(cyc);
            if (y_inc === 1'b1) y_inc_log.push_back(cyc);
            if (y_dec === 1'b1) y_dec_log.push_back(cyc);
            if ((x_inc === 1'b1 && x_dec === 1'b1) || (y_inc === 1'b1 && y_dec === 1'b1))
                both_seen = 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run exceeded time limit, passed %0d of %0d", pass_cnt, chk_cnt);
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input int actual, input int expected);
        chk_cnt++;
        if (actual == expected) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    endtask

    // sel: 0 x_inc, 1 x_dec, 2 y_inc, 3 y_dec; -1 when that pulse never happened.
    function automatic int pulse_at(input int sel, input int idx);
        int r;
        r = -1;
        case (sel)
            0: if (idx < x_inc_log.size()) r = x_inc_log[idx];
            1: if (idx < x_dec_log.size()) r = x_dec_log[idx];
            2: if (idx < y_inc_log.size()) r = y_inc_log[idx];
            3: if (idx < y_dec_log.size()) r = y_dec_log[idx];
            default: r = -1;
        endcase
        return r;
    endfunction

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(negedge SYSCLK);
            #1;
        end
    endtask

    task automatic clear_logs();
        x_inc_log.delete();
        x_dec_log.delete();
        y_inc_log.delete();
        y_dec_log.delete();
    endtask

    task automatic start_run(input logic [3:0] t);
        @(negedge SYSCLK);
        #1;
        reset2 = 1'b1;
        tilt   = t;
        repeat (3) @(negedge SYSCLK);
        #1;
        clear_logs();
        reset2 = 1'b0;
    endtask

    initial begin
        reset2 = 1'b1;
        tilt   = 4'b0001;

        // Reset hold with a tilt applied
        repeat (50) @(negedge SYSCLK);
        #1;
        check_val("rst_known", int'($isunknown({x_inc, x_dec, y_inc, y_dec, x_speed, y_speed})), 0);
        check_val("rst_outs", int'({x_inc, x_dec, y_inc, y_dec}), 0);
        check_val("rst_speed", int'({x_speed, y_speed}), 0);
        check_val("rst_pulses", x_inc_log.size() + x_dec_log.size() + y_inc_log.size() + y_dec_log.size(), 0);

        // Basic right: entry step after the 4th tick, then ramping train
        start_run(4'b0010);
        wait_cyc(39);
        check_val("r_pre", int'(x_inc), 0);
        check_val("r_pre_n", x_inc_log.size(), 0);
        wait_cyc(40);
        check_val("r_first", int'(x_inc), 1);
        check_val("r_spd_entry", int'(x_speed), 0);
        wait_cyc(41);
        check_val("r_single", int'(x_inc), 0);
        wait_cyc(69);
        check_val("r_spd0", int'(x_speed), 0);
        wait_cyc(70);
        check_val("r_spd1", int'(x_speed), 1);
        wait_cyc(300);
        check_val("r_n", x_inc_log.size(), 7);
        check_val("r_p1", pulse_at(0, 1), 100);
        check_val("r_p2", pulse_at(0, 2), 140);
        check_val("r_p6", pulse_at(0, 6), 300);
        check_val("r_spd_sat", int'(x_speed), 2);
        check_val("r_other", x_dec_log.size() + y_inc_log.size() + y_dec_log.size(), 0);

        // Ramp on y (backward -> y_inc)
        start_run(4'b1000);
        wait_cyc(99);
        check_val("y_spd1", int'(y_speed), 1);
        wait_cyc(100);
        check_val("y_spd2", int'(y_speed), 2);
        check_val("y_pulse100", int'(y_inc), 1);
        wait_cyc(400);
        check_val("y_spd_sat", int'(y_speed), 2);
        check_val("y_p0", pulse_at(2, 0), 40);
        check_val("y_p1", pulse_at(2, 1), 100);
        check_val("y_p2", pulse_at(2, 2), 140);
        check_val("y_n", y_inc_log.size(), 9);
        check_val("y_other", x_inc_log.size() + x_dec_log.size() + y_dec_log.size(), 0);

        // Short glitch: three ticks of left, then neutral
        start_run(4'b0001);
        wait_cyc(35);
        tilt = 4'b0000;
        wait_cyc(200);
        check_val("g_none", x_dec_log.size(), 0);
        check_val("g_spd", int'(x_speed), 0);
        wait_cyc(205);
        tilt = 4'b0001;
        wait_cyc(300);
        check_val("g_requal", pulse_at(1, 0), 240);
        check_val("g_n", x_dec_log.size(), 2);

        // Reversal from right at speed 2
        start_run(4'b0010);
        wait_cyc(105);
        tilt = 4'b0001;
        wait_cyc(109);
        check_val("v_spd_before", int'(x_speed), 2);
        wait_cyc(110);
        check_val("v_spd_drop", int'(x_speed), 0);
        check_val("v_no_pulse", int'({x_inc, x_dec}), 0);
        wait_cyc(139);
        check_val("v_pre", x_dec_log.size(), 0);
        wait_cyc(140);
        check_val("v_first", int'(x_dec), 1);
        wait_cyc(150);
        check_val("v_inc_n", x_inc_log.size(), 2);
        check_val("v_dec_at", pulse_at(1, 0), 140);

        // Both bits of a pair: neutral
        start_run(4'b0011);
        wait_cyc(200);
        check_val("n_x", x_inc_log.size() + x_dec_log.size(), 0);
        check_val("n_y", y_inc_log.size() + y_dec_log.size(), 0);
        check_val("n_spd", int'(x_speed), 0);

        // Simultaneous x right and y forward
        start_run(4'b0110);
        wait_cyc(40);
        check_val("s_coinc", int'({x_inc, y_dec}), 3);
        wait_cyc(150);
        check_val("s_x_n", x_inc_log.size(), 3);
        check_val("s_y_n", y_dec_log.size(), 3);
        check_val("s_y_p1", pulse_at(3, 1), 100);
        check_val("s_other", x_dec_log.size() + y_inc_log.size(), 0);

        // Reset asserted on the edge that would carry the entry step
        start_run(4'b0010);
        wait_cyc(39);
        reset2 = 1'b1;
        @(negedge SYSCLK);
        #1;
        check_val("k_killed", int'(x_inc), 0);
        check_val("k_log", x_inc_log.size(), 0);
        reset2 = 1'b0;

        check_val("excl", both_seen, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
